// File: rtl/start_conv_out_q_if.sv
// start_conv_out_q_if: conv engine / output writer descriptor-queue bundle.
// slave is the queue's view; master is the engine/writer/testbench view.
interface start_conv_out_q_if #(
  parameter int DEPTH = 4,
  parameter int KW = 16,
  parameter int CGW = 8,
  parameter int AW = 32,
  parameter int WW = 12,
  parameter int PW = 24
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic enable;
  logic isNextVolumeReady;
  logic isPrefetchNextVolume;
  logic isPrefetchNextVolume_next;
  logic out_done;
  logic new_params;
  logic [KW-1:0] new_kOut;
  logic [KW-1:0] ks;
  logic [KW-1:0] kCurLast;
  logic [CGW-1:0] numGroups;
  logic [CGW-1:0] usedCG0;
  logic [CGW-1:0] usedCGLast;
  logic doRes;
  logic doUpSample;
  logic [WW-1:0] outputBufW1;
  logic [WW-1:0] outputBufH1Orig;
  logic [WW-1:0] outW;
  logic [AW-1:0] outputAddr;
  logic [AW-1:0] outputFrameStart;
  logic [PW-1:0] misc_in;
  logic accept;
  logic waiting_out;
  logic isOnOutput;
  logic set_LastOutput;
  logic [KW-1:0] kOut;
  logic [CGW-1:0] outputIdxMax;
  logic doRes_out;
  logic doUpSample_out;
  logic [WW-1:0] outputBufW1_out;
  logic [WW-1:0] outputBufH1_out;
  logic [WW-1:0] outW_out;
  logic [WW-1:0] outW_out2;
  logic [AW-1:0] outputAddr_out;
  logic [AW-1:0] outputFrameStart_out;
  logic [PW-1:0] misc_out;
  logic [OW-1:0] occupancy;
  modport slave (
    input enable, isNextVolumeReady, isPrefetchNextVolume, isPrefetchNextVolume_next,
    input out_done, new_params, new_kOut, ks, kCurLast, numGroups, usedCG0, usedCGLast,
    input doRes, doUpSample, outputBufW1, outputBufH1Orig, outW, outputAddr,
    input outputFrameStart, misc_in,
    output accept, waiting_out, isOnOutput, set_LastOutput, kOut, outputIdxMax,
    output doRes_out, doUpSample_out, outputBufW1_out, outputBufH1_out, outW_out,
    output outW_out2, outputAddr_out, outputFrameStart_out, misc_out, occupancy
  );
  modport master (
    output enable, isNextVolumeReady, isPrefetchNextVolume, isPrefetchNextVolume_next,
    output out_done, new_params, new_kOut, ks, kCurLast, numGroups, usedCG0, usedCGLast,
    output doRes, doUpSample, outputBufW1, outputBufH1Orig, outW, outputAddr,
    output outputFrameStart, misc_in,
    input accept, waiting_out, isOnOutput, set_LastOutput, kOut, outputIdxMax,
    input doRes_out, doUpSample_out, outputBufW1_out, outputBufH1_out, outW_out,
    input outW_out2, outputAddr_out, outputFrameStart_out, misc_out, occupancy
  );
endinterface

// File: rtl/start_conv_out_q.sv
// start_conv_out_q: DEPTH-deep FIFO of output-write descriptors captured on channel-group switch.
// START_CONV_OUT_Q_STATS_EN adds stall_cycles and max_occupancy counters.
module start_conv_out_q #(
  parameter int DEPTH = 4,
  parameter int KW = 16,
  parameter int CGW = 8,
  parameter int AW = 32,
  parameter int WW = 12,
  parameter int PW = 24
) (
  input logic clock,
  input logic resetN,
  start_conv_out_q_if.slave bus
`ifdef START_CONV_OUT_Q_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [$clog2(DEPTH):0] max_occupancy
`endif
);
  localparam int PTW = $clog2(DEPTH);
  localparam int OW = PTW + 1;
  localparam int DW = CGW + 2 + 4 * WW + 2 * AW + PW;
  logic [OW-1:0] count;
  logic [PTW-1:0] rd, wr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] din, head;
  logic [KW-1:0] k_out;
  logic waiting, pop;
  logic [CGW-1:0] idx_max;
  logic [WW-1:0] outw2;
  assign pop = bus.out_done && count != '0;
  assign bus.accept = bus.enable && (count < OW'(DEPTH) || pop);
  // limit is chosen from kOut before this accept's stride is applied
  assign idx_max = (k_out == bus.kCurLast) ? bus.usedCGLast : bus.usedCG0;
  assign outw2 = bus.doUpSample ? bus.outW - bus.outputBufW1 : '0;
  assign din = {idx_max, bus.doRes, bus.doUpSample, bus.outputBufW1, bus.outputBufH1Orig,
                bus.outW, outw2, bus.outputAddr, bus.outputFrameStart, bus.misc_in};
  assign head = (count != '0) ? mem[rd] : '0;
  assign {bus.outputIdxMax, bus.doRes_out, bus.doUpSample_out, bus.outputBufW1_out,
          bus.outputBufH1_out, bus.outW_out, bus.outW_out2, bus.outputAddr_out,
          bus.outputFrameStart_out, bus.misc_out} = head;
  assign bus.isOnOutput = count != '0;
  assign bus.occupancy = count;
  assign bus.kOut = k_out;
  assign bus.waiting_out = waiting;
  assign bus.set_LastOutput = bus.accept && !bus.isNextVolumeReady &&
                              !bus.isPrefetchNextVolume && !bus.isPrefetchNextVolume_next;
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      count <= '0;
      rd <= '0;
      wr <= '0;
      k_out <= '0;
      waiting <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (bus.accept) begin
        mem[wr] <= din;
        wr <= wr + PTW'(1);
      end
      if (pop) rd <= rd + PTW'(1);
      count <= count + OW'(bus.accept) - OW'(pop);
      k_out <= bus.new_params ? bus.new_kOut :
               bus.accept ? k_out + KW'(bus.numGroups) + bus.ks : k_out;
      waiting <= bus.accept ? 1'b0 : bus.enable ? 1'b1 : waiting;
    end
`ifdef START_CONV_OUT_Q_STATS_EN
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      stall_cycles <= '0;
      max_occupancy <= '0;
    end else begin
      if (bus.enable && !bus.accept && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (count > max_occupancy) max_occupancy <= count;
    end
`endif
endmodule

// File: tb/tb_start_conv_out_q.sv
// tb_start_conv_out_q: directed table plus hand sequences for the descriptor queue.
module tb_start_conv_out_q;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  start_conv_out_q_if #(.DEPTH(4)) bus();
`ifdef START_CONV_OUT_Q_STATS_EN
  logic [31:0] stall_cycles;
  logic [2:0] max_occupancy;
`endif
  start_conv_out_q #(.DEPTH(4)) dut (
    .clock(clock),
    .resetN(resetN),
    .bus(bus)
`ifdef START_CONV_OUT_Q_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .max_occupancy(max_occupancy)
`endif
  );
  always #5 clock = ~clock;

  typedef struct {
    int en, od, np, nk, nr, pf, pn;
    int ea, el, ec, ek, ew, eaddr, eidx;
  } vec_t;
  vec_t v [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic defaults();
    bus.enable = 0; bus.out_done = 0; bus.new_params = 0; bus.new_kOut = '0;
    bus.isNextVolumeReady = 0; bus.isPrefetchNextVolume = 0; bus.isPrefetchNextVolume_next = 0;
    bus.ks = 16'd1; bus.kCurLast = 16'd8; bus.numGroups = 8'd2;
    bus.usedCG0 = 8'd7; bus.usedCGLast = 8'd3; bus.doRes = 0; bus.doUpSample = 0;
    bus.outputBufW1 = 12'd16; bus.outputBufH1Orig = 12'd8; bus.outW = 12'd64;
    bus.outputAddr = '0; bus.outputFrameStart = 32'h1000; bus.misc_in = 24'hABCDE;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic up_case(input logic up, input int ow, input int bw, input int exp);
    defaults();
    bus.enable = 1; bus.doUpSample = up; bus.outW = 12'(ow); bus.outputBufW1 = 12'(bw);
    #3 chk("up_on_before", 32'(bus.isOnOutput), 0);
    tick();
    defaults();
    chk("up_on_after", 32'(bus.isOnOutput), 1);
    chk("outW_out2", 32'(bus.outW_out2), 32'(exp));
    chk("misc_out", 32'(bus.misc_out), 32'hABCDE);
    bus.out_done = 1;
    tick();
    bus.out_done = 0;
  endtask

  initial begin
    defaults();
    v[0]  = '{0,0,1,5, 0,0,0, 0,0,0,5,0, 0,0};
    v[1]  = '{1,0,0,0, 0,0,0, 1,1,1,8,0, 101,7};
    v[2]  = '{1,0,0,0, 1,0,0, 1,0,2,11,0, 101,7};
    v[3]  = '{1,0,0,0, 0,1,0, 1,0,3,14,0, 101,7};
    v[4]  = '{1,0,0,0, 0,0,1, 1,0,4,17,0, 101,7};
    v[5]  = '{1,0,0,0, 0,0,0, 0,0,4,17,1, 101,7};
    v[6]  = '{0,0,0,0, 0,0,0, 0,0,4,17,1, 101,7};
    v[7]  = '{1,1,0,0, 0,0,0, 1,1,4,20,0, 102,3};
    v[8]  = '{0,1,0,0, 0,0,0, 0,0,3,20,0, 103,7};
    v[9]  = '{1,1,1,2, 0,0,0, 1,1,3,2,0, 104,7};
    v[10] = '{0,1,0,0, 0,0,0, 0,0,2,2,0, 107,7};
    v[11] = '{0,1,0,0, 0,0,0, 0,0,1,2,0, 109,7};
    v[12] = '{0,1,0,0, 0,0,0, 0,0,0,2,0, 0,0};
    v[13] = '{0,1,0,0, 0,0,0, 0,0,0,2,0, 0,0};
    #12 resetN = 1'b1;
    tick();
    chk("rst_count", 32'(bus.occupancy), 0);
    chk("rst_kOut", 32'(bus.kOut), 0);
    chk("rst_wait", 32'(bus.waiting_out), 0);
    chk("rst_on", 32'(bus.isOnOutput), 0);
    chk("rst_addr", bus.outputAddr_out, 0);
    for (int i = 0; i < 14; i++) begin
      defaults();
      bus.enable = 1'(v[i].en); bus.out_done = 1'(v[i].od); bus.new_params = 1'(v[i].np);
      bus.new_kOut = 16'(v[i].nk); bus.isNextVolumeReady = 1'(v[i].nr);
      bus.isPrefetchNextVolume = 1'(v[i].pf); bus.isPrefetchNextVolume_next = 1'(v[i].pn);
      bus.outputAddr = 32'(100 + i);
      #3;
      chk($sformatf("accept[%0d]", i), 32'(bus.accept), 32'(v[i].ea));
      chk($sformatf("last[%0d]", i), 32'(bus.set_LastOutput), 32'(v[i].el));
      tick();
      chk($sformatf("count[%0d]", i), 32'(bus.occupancy), 32'(v[i].ec));
      chk($sformatf("kOut[%0d]", i), 32'(bus.kOut), 32'(v[i].ek));
      chk($sformatf("wait[%0d]", i), 32'(bus.waiting_out), 32'(v[i].ew));
      chk($sformatf("head_addr[%0d]", i), bus.outputAddr_out, 32'(v[i].eaddr));
      chk($sformatf("idx_max[%0d]", i), 32'(bus.outputIdxMax), 32'(v[i].eidx));
    end
    up_case(1, 64, 16, 48);
    up_case(0, 64, 16, 0);
    up_case(1, 4, 16, 4084);
    defaults();
    bus.enable = 1; bus.outputAddr = 32'd200;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.out_done = 1; bus.outputAddr = 32'(201 + i);
      tick();
      chk($sformatf("wrap_addr[%0d]", i), bus.outputAddr_out, 32'(201 + i));
      chk($sformatf("wrap_occ[%0d]", i), 32'(bus.occupancy), 1);
    end
    defaults();
    bus.out_done = 1;
    tick();
    chk("wrap_empty", 32'(bus.isOnOutput), 0);
    defaults();
    bus.new_params = 1; bus.new_kOut = 16'd9;
    tick();
    defaults();
    bus.enable = 1;
    tick();
    tick();
    defaults();
    chk("pre_rst_count", 32'(bus.occupancy), 2);
    #2 resetN = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.occupancy), 0);
    chk("mid_rst_kOut", 32'(bus.kOut), 0);
    chk("mid_rst_wait", 32'(bus.waiting_out), 0);
    chk("mid_rst_on", 32'(bus.isOnOutput), 0);
    #3 resetN = 1'b1;
    tick();
    chk("post_rst_count", 32'(bus.occupancy), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/start_conv_out_q.md
Name: start_conv_out_q

Overview:
- Parametrised successor to the single-slot output-start latch.
- Captures output-write descriptors when the conv engine switches channel group, and holds up to DEPTH of them in a FIFO.
- Presents the head descriptor to the output writer until it is retired.
- Tracks the output kernel index kOut and the per-group output index limit, and flags the last output of a volume.

Parameters:
- DEPTH, 4: descriptor slots; power of 2, at least 2.
- KW, 16: width of layer_addr_t fields (kt, ks, kOut, kCurLast, new_kOut).
- CGW, 8: width of cg_addr_t fields (numGroups, usedCG0, usedCGLast, outputIdxMax).
- AW, 32: width of mem_addr_t fields (outputAddr, outputFrameStart).
- WW, 12: width of width_t/out_width_t fields (outputBufW1, outputBufH1, outW, outW2).
- PW, 24: width of the packed misc bundle: {outFrameSize, outputAddrGap, maxpool_stride, k, curSeq, newWriteInst}.

Ports:
- clock in 1: clock.
- resetN in 1: asynchronous active-low reset.
- enable in 1: group-switch request from the conv engine.
- isNextVolumeReady in 1: next volume already resident.
- isPrefetchNextVolume in 1: prefetch in progress.
- isPrefetchNextVolume_next in 1: prefetch starting next cycle.
- out_done in 1: writer retires the head descriptor.
- new_params in 1: load kOut from new_kOut.
- new_kOut in KW: kOut reload value.
- ks, kCurLast in KW: kOut stride component and last-group index.
- numGroups, usedCG0, usedCGLast in CGW: group count and per-group limits.
- doRes, doUpSample in 1: residual add / upsample mode.
- outputBufW1, outputBufH1Orig, outW in WW: geometry.
- outputAddr, outputFrameStart in AW: write and frame base addresses.
- misc_in in PW: packed misc fields.
- accept out 1: descriptor captured this cycle (combinational; replaces cgSwitchOutput and set_out_params).
- waiting_out out 1: registered stall flag.
- isOnOutput out 1: head descriptor valid.
- set_LastOutput out 1: combinational last-output flag.
- kOut out KW: current output kernel index.
- outputIdxMax out CGW: head descriptor field.
- doRes_out, doUpSample_out out 1: head descriptor fields.
- outputBufW1_out, outputBufH1_out, outW_out, outW_out2 out WW: head descriptor fields.
- outputAddr_out, outputFrameStart_out out AW: head descriptor fields.
- misc_out out PW: head descriptor field.
- occupancy out clog2(DEPTH)+1: descriptor count.

Behaviour:
- Reset:
  - Asynchronous on resetN low: count, read pointer, write pointer, kOut and waiting_out go to 0; all storage is cleared.
  - All head outputs read 0 while the FIFO is empty.
- pop = out_done && count!=0. A pop on an empty FIFO is ignored.
- Push acceptance:
  - accept = enable && (count<DEPTH || pop). A full FIFO accepts when a pop occurs in the same cycle.
- On accept, write one descriptor at the write pointer:
  - Geometry, address, mode and misc inputs as presented.
  - outputIdxMax = (kOut==kCurLast) ? usedCGLast : usedCG0, using the pre-update kOut.
  - outW2 = doUpSample ? outW-outputBufW1 (modulo 2^WW) : 0.
- kOut update, next cycle:
  - new_params: kOut = new_kOut. This has priority over an accept in the same cycle.
  - else accept: kOut = kOut + numGroups + ks, truncated to KW bits; numGroups is zero-extended.
  - else kOut holds.
- waiting_out:
  - Next value is 1 when enable && !accept; 0 when accept.
  - Holds otherwise.
- set_LastOutput = accept && !isNextVolumeReady && !isPrefetchNextVolume && !isPrefetchNextVolume_next.
- count update: count + accept - pop. Pointers wrap modulo DEPTH.
- Head timing:
  - isOnOutput = count!=0. Head outputs reflect the slot at the read pointer.
  - A descriptor pushed into an empty FIFO appears on the outputs the cycle after accept (1-cycle latency).
  - Simultaneous push and pop on an empty FIFO cannot occur.

Optional Feature:
- Macro: START_CONV_OUT_Q_STATS_EN.
- When defined:
  - Adds output stall_cycles (32 bits): counts cycles with enable && !accept.
  - Adds output max_occupancy (clog2(DEPTH)+1 bits): the high-water mark of count.
  - Both reset to 0 and saturate.
- When undefined, neither port nor logic exists.

Test Plan:
- Reset mid-operation: push 2 descriptors, pulse resetN low asynchronously between clock edges -> count, kOut and waiting_out are 0 immediately; isOnOutput=0.
- kOut stride: DEPTH=4, new_params with new_kOut=5, then 3 accepts with numGroups=2, ks=1 -> kOut=5,8,11,14. With kCurLast=8, the 2nd descriptor has outputIdxMax=usedCGLast=3; the others have usedCG0=7.
- Full FIFO: 4 accepts with no pops, 5th enable -> accept=0; waiting_out=1 the next cycle; kOut unchanged. Then enable with out_done -> accept=1; count stays 4; waiting_out=0.
- Upsample: doUpSample=1, outW=64, outputBufW1=16 -> outW_out2=48. doUpSample=0 -> 0. outW=4, outputBufW1=16 -> wraps to 2^WW-12.
- Last output: accept with isNextVolumeReady=0 and both prefetch flags 0 -> set_LastOutput=1. Any flag at 1 -> 0. No accept -> 0.
- Pointer wrap: 10 push/pop pairs with incrementing outputAddr -> head outputAddr_out matches push order in every cycle; occupancy never exceeds 1.
